// File: rtl/orbit_frame_loader.sv
// orbit_frame_loader
// ------------------
// Ping-pong buffer writer for the orbit serializer. Telemetry words are
// written into the RAM half the serializer is NOT reading (bank ~iSwitch).
// Every serializer bank switch (a change on iSwitch) restarts filling the
// freed half at word index 0.
//
// Optional feature macro: LOADER_DROPCNT_EN
//   defined   -> oDropCnt port and 16-bit saturating dropped-word counter
//   undefined -> port and counter omitted, dropped words silently discarded
//
// Ports:
//   iClkOrb    system clock, shared with the serializer
//   reset      asynchronous, active-low reset
//   iData      12-bit telemetry word
//   iDataVal   single-cycle valid strobe for iData
//   iSwitch    serializer bank-switch level (serializer reads bank iSwitch)
//   oWrAddr    RAM write address {bank, word index}
//   oWrData    RAM write data
//   oWrEn      RAM write enable, one cycle per word
//   oFrameRdy  pulse alongside the write of the last word of a bank
//   oShort     pulse one cycle after a bank switch that cut a bank short
//   oBusy      high while in FILL
//   oDropCnt   saturating dropped-word count (LOADER_DROPCNT_EN only)

module orbit_frame_loader #(
    parameter int FRAME_WORDS = 2048,
    parameter int ADDR_W      = 11
) (
`ifdef LOADER_DROPCNT_EN
    output logic [15:0]       oDropCnt,
`endif
    input  logic              iClkOrb,
    input  logic              reset,
    input  logic [11:0]       iData,
    input  logic              iDataVal,
    input  logic              iSwitch,
    output logic [ADDR_W:0]   oWrAddr,
    output logic [11:0]       oWrData,
    output logic              oWrEn,
    output logic              oFrameRdy,
    output logic              oShort,
    output logic              oBusy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t            state;
    logic              swR;
    logic [ADDR_W-1:0] wrIdx;

    logic              tog;
    logic              accept;
    logic [ADDR_W-1:0] idxEff;

    // A toggle is applied before a coincident word, so a word arriving in the
    // toggle cycle is always accepted and lands at index 0 of the new bank.
    always_comb begin
        tog    = iSwitch ^ swR;
        accept = iDataVal && (tog || (state == FILL));
        idxEff = tog ? '0 : wrIdx;
    end

    always_ff @(posedge iClkOrb or negedge reset) begin
        if (!reset) begin
            state     <= SYNC;
            swR       <= 1'b0;
            wrIdx     <= '0;
            oWrAddr   <= '0;
            oWrData   <= '0;
            oWrEn     <= 1'b0;
            oFrameRdy <= 1'b0;
            oShort    <= 1'b0;
            oBusy     <= 1'b0;
        end else begin
            swR       <= iSwitch;
            oWrEn     <= 1'b0;
            oFrameRdy <= 1'b0;
            // In FILL the bank is by construction not yet full, so any
            // toggle seen there cuts the current frame short.
            oShort    <= tog && (state == FILL);

            if (accept) begin
                oWrEn   <= 1'b1;
                oWrAddr <= {~iSwitch, idxEff};
                oWrData <= iData;
                if (idxEff == LAST_IDX) begin
                    oFrameRdy <= 1'b1;
                    wrIdx     <= '0;
                    state     <= FULL;
                    oBusy     <= 1'b0;
                end else begin
                    wrIdx <= idxEff + ADDR_W'(1);
                    state <= FILL;
                    oBusy <= 1'b1;
                end
            end else if (tog) begin
                wrIdx <= '0;
                state <= FILL;
                oBusy <= 1'b1;
            end
        end
    end

`ifdef LOADER_DROPCNT_EN
    always_ff @(posedge iClkOrb or negedge reset) begin
        if (!reset) begin
            oDropCnt <= '0;
        end else if (iDataVal && !accept && (oDropCnt != 16'hFFFF)) begin
            oDropCnt <= oDropCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_orbit_frame_loader.sv
// Testbench for orbit_frame_loader: directed phases with randomized data and
// gaps, checked every cycle against a frame-level behavioural model.

module tb_orbit_frame_loader;

    localparam int FW = 2048;

    logic        iClkOrb = 1'b0;
    logic        reset   = 1'b0;
    logic [11:0] iData   = '0;
    logic        iDataVal = 1'b0;
    logic        iSwitch = 1'b0;
    logic [11:0] oWrAddr;
    logic [11:0] oWrData;
    logic        oWrEn;
    logic        oFrameRdy;
    logic        oShort;
    logic        oBusy;
`ifdef LOADER_DROPCNT_EN
    logic [15:0] oDropCnt;
`endif

    int checks = 0;
    int errors = 0;

    // Model: phase 0 = waiting for first switch, 1 = filling, 2 = bank full
    int   mPhase;
    int   mIdx;
    int   mDrop;
    bit   mSw;
    logic [11:0] eAddr, eData;
    logic        eWrEn, eFrame, eShort, eBusy;

    orbit_frame_loader #(.FRAME_WORDS(FW), .ADDR_W(11)) dut (
`ifdef LOADER_DROPCNT_EN
        .oDropCnt (oDropCnt),
`endif
        .iClkOrb  (iClkOrb),
        .reset    (reset),
        .iData    (iData),
        .iDataVal (iDataVal),
        .iSwitch  (iSwitch),
        .oWrAddr  (oWrAddr),
        .oWrData  (oWrData),
        .oWrEn    (oWrEn),
        .oFrameRdy(oFrameRdy),
        .oShort   (oShort),
        .oBusy    (oBusy)
    );

    always #5 iClkOrb = ~iClkOrb;

    task automatic modelReset();
        mPhase = 0; mIdx = 0; mDrop = 0; mSw = 0;
        eAddr = '0; eData = '0; eWrEn = 0; eFrame = 0; eShort = 0; eBusy = 0;
    endtask

    // One clock edge of behaviour, written from the frame rules.
    task automatic modelEdge(input logic [11:0] d, input logic v, input logic s);
        eWrEn = 0; eFrame = 0; eShort = 0;
        if (s != mSw) begin
            if (mPhase == 1) eShort = 1;
            mPhase = 1;
            mIdx   = 0;
        end
        mSw = s;
        if (v) begin
            if (mPhase == 1) begin
                eWrEn = 1;
                eAddr = 12'((s ? 0 : FW) + mIdx);
                eData = d;
                mIdx++;
                if (mIdx == FW) begin
                    eFrame = 1;
                    mPhase = 2;
                    mIdx   = 0;
                end
            end else if (mDrop < 65535) begin
                mDrop++;
            end
        end
        eBusy = (mPhase == 1);
    endtask

    task automatic checkAll(input string tag);
        checks++;
        assert (oWrEn === eWrEn) else begin
            errors++; $error("FAIL %s wrEn got %b want %b", tag, oWrEn, eWrEn);
        end
        checks++;
        assert (oWrAddr === eAddr) else begin
            errors++; $error("FAIL %s wrAddr got %h want %h", tag, oWrAddr, eAddr);
        end
        checks++;
        assert (oWrData === eData) else begin
            errors++; $error("FAIL %s wrData got %h want %h", tag, oWrData, eData);
        end
        checks++;
        assert (oFrameRdy === eFrame) else begin
            errors++; $error("FAIL %s frameRdy got %b want %b", tag, oFrameRdy, eFrame);
        end
        checks++;
        assert (oShort === eShort) else begin
            errors++; $error("FAIL %s short got %b want %b", tag, oShort, eShort);
        end
        checks++;
        assert (oBusy === eBusy) else begin
            errors++; $error("FAIL %s busy got %b want %b", tag, oBusy, eBusy);
        end
`ifdef LOADER_DROPCNT_EN
        checks++;
        assert (oDropCnt === 16'(mDrop)) else begin
            errors++; $error("FAIL %s dropCnt got %0d want %0d", tag, oDropCnt, mDrop);
        end
`endif
    endtask

    task automatic step(input logic [11:0] d, input logic v, input logic s, input string tag);
        @(negedge iClkOrb);
        iData = d; iDataVal = v; iSwitch = s;
        @(posedge iClkOrb);
        modelEdge(d, v, s);
        #1;
        checkAll(tag);
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for a clock.
    task automatic midReset(input string tag);
        @(negedge iClkOrb);
        iDataVal = 0;
        #2;
        reset = 0;
        modelReset();
        #1;
        checkAll(tag);
        @(negedge iClkOrb);
        reset = 1;
    endtask

    initial begin
        logic sw;
        modelReset();
        #12;
        checkAll("reset");
        @(negedge iClkOrb);
        reset = 1;
        $display("reset released, outputs cleared");

        sw = 0;
        for (int i = 0; i < 5; i++) step(12'($urandom), 1, sw, "sync_drop");
        $display("sync: 5 words dropped");

        sw = 1;
        step('0, 0, sw, "tog_to_fill");
        for (int i = 0; i < FW; i++) step(12'(i), 1, sw, "frame0");
        $display("frame0: %0d words written to bank 0", FW);
        step(12'($urandom), 1, sw, "full_drop");
        $display("full: extra word dropped");

        sw = 0;
        step(12'hABC, 1, sw, "tog_data_full");
        step(12'($urandom), 1, sw, "idx1_after_tog");
        $display("toggle+word from FULL: 12'hABC at bank 1 index 0");
        for (int i = 0; i < 98; i++) step(12'($urandom), 1'($urandom), sw, "fill_bank1");

        sw = 1;
        step('0, 0, sw, "short_tog");
        step(12'($urandom), 1, sw, "after_short");
        $display("short frame on bank 1, restart on bank 0");
        for (int i = 0; i < 99; i++) step(12'($urandom), 1, sw, "fill_bank0");
        sw = 0;
        step('0, 0, sw, "short_tog2");
        step(12'($urandom), 1, sw, "word_at_800");
        $display("short frame on bank 0, next word at 12'h800");

        for (int i = 0; i < 299; i++) step(12'($urandom), 1, sw, "pre_reset_fill");
        midReset("mid_reset");
        for (int i = 0; i < 4; i++) step(12'($urandom), 1, sw, "post_reset_drop");
        sw = 1;
        step(12'($urandom), 1, sw, "post_reset_tog");
        $display("mid-FILL reset: block back in SYNC, refill after toggle");

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 399) == 0) sw = ~sw;
            step(12'($urandom), 1'($urandom), sw, "random");
        end
        $display("random traffic: 2500 cycles");

        midReset("reset_for_sat");
        for (int i = 0; i < 70000; i++) step(12'($urandom), 1, sw, "saturate");
        $display("saturation: 70000 drops");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
